// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package s2p_pkg;

  typedef enum logic {IDLE, SHIFT} rx_state_t;

  // Width of a counter that must hold values 0..w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/s2p_obuf.sv
// One-entry valid/ready holding register for completed words.
// A push is accepted when the register is empty or is being drained in the
// same cycle; otherwise the pushed word is dropped and ovf pulses.
module s2p_obuf #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         rdy,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         ovf
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;
  logic         ovf_q, ovf_d;
  logic         accept;

  // Next-state logic: load on accepted push, clear on drain, flag drops.
  always_comb begin
    accept = !full_q || rdy;
    data_d = data_q;
    full_d = full_q;
    ovf_d  = 1'b0;
    if (push) begin
      if (accept) begin
        data_d = data;
        full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (full_q && rdy) begin
      full_d = 1'b0;
    end
  end

  // Register the holding entry and the overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: reassembles LSB-first W-bit frames, reports
// wrong-length frames and hands complete words to a one-entry output buffer.
module s2p_rx
  import s2p_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_vld,
  input  logic         sin_last,
  output logic [W-1:0] dout,
  output logic         dout_vld,
  input  logic         dout_rdy,
  output logic         frm_err,
  output logic         ovf
);

  localparam int CW = cnt_w(W);

  rx_state_t    state_q, state_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [W-1:0]  sr_q, sr_d;
  logic          frm_err_q, frm_err_d;
  logic [CW-1:0] cur_cnt;
  logic          at_end;
  logic [W-1:0]  word;
  logic          push;

  // Receive datapath: place each valid bit, then decide complete/short/long.
  always_comb begin
    cur_cnt   = (state_q == IDLE) ? '0 : bcnt_q;
    at_end    = (cur_cnt == CW'(W - 1));
    word      = sr_q;
    for (int i = 0; i < W; i++) begin
      if (cur_cnt == CW'(i)) word[i] = sin;
    end
    sr_d      = sr_q;
    bcnt_d    = bcnt_q;
    state_d   = state_q;
    frm_err_d = 1'b0;
    push      = 1'b0;
    if (sin_vld) begin
      sr_d = word;
      if (sin_last && at_end) begin
        push    = 1'b1;
        bcnt_d  = '0;
        state_d = IDLE;
      end else if (sin_last || at_end) begin
        frm_err_d = 1'b1;
        bcnt_d    = '0;
        state_d   = IDLE;
      end else begin
        bcnt_d  = cur_cnt + CW'(1);
        state_d = SHIFT;
      end
    end
  end

  // Receive FSM, bit counter, shift register and frame-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      sr_q      <= '0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      sr_q      <= sr_d;
      frm_err_q <= frm_err_d;
    end
  end

  s2p_obuf #(.W(W)) u_obuf (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .data (word),
    .rdy  (dout_rdy),
    .dout (dout),
    .full (dout_vld),
    .ovf  (ovf)
  );

  assign frm_err = frm_err_q;

endmodule
